// File: rtl/hp_fp_pkg.sv
// Shared half-precision field widths, exception codes and divider state encoding.
package hp_fp_pkg;

    localparam int EXP_W      = 5;
    localparam int MAN_W      = 10;
    localparam int HP_BIAS    = 15;
    localparam int HP_EXP_MAX = 30;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_UNF  = 2'b10;
    localparam logic [1:0] EXC_INV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPECIAL,
        ST_DIV,
        ST_NORM
    } state_t;

endpackage

// File: rtl/hp_operand_classify.sv
// Combinational classification of one half-precision operand.
module hp_operand_classify
    import hp_fp_pkg::*;
(
    input  logic [15:0] operand,
    output logic        is_zero,
    output logic        is_denorm,
    output logic        is_inf,
    output logic        is_nan
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f = operand[MAN_W +: EXP_W];
    assign man_f = operand[MAN_W-1:0];

    assign is_zero   = (exp_f == '0) && (man_f == '0);
    assign is_denorm = (exp_f == '0) && (man_f != '0);
    assign is_inf    = (exp_f == '1) && (man_f == '0);
    assign is_nan    = (exp_f == '1) && (man_f != '0);

endmodule

// File: rtl/hp_divider.sv
// Sequential half-precision divider, restoring division one quotient bit per cycle.
// Optional round-to-nearest-even enabled by defining HP_DIV_ROUND_NEAREST_EN.
module hp_divider
    import hp_fp_pkg::*;
#(
    parameter int EXP_BIAS = HP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] hp_inA,
    input  logic [15:0] hp_inB,
    output logic        busy,
    output logic        done,
    output logic [15:0] hp_quotient,
    output logic [1:0]  Exceptions
);

`ifdef HP_DIV_ROUND_NEAREST_EN
    localparam int DIV_ITERS = 14;
`else
    localparam int DIV_ITERS = 12;
`endif
    localparam logic signed [6:0] E_MAX = 7'(HP_EXP_MAX);
    localparam logic signed [6:0] E_MIN = 7'sd1;

    state_t state_q, state_d;

    logic                  a_zero, a_den, a_inf, a_nan;
    logic                  b_zero, b_den, b_inf, b_nan;
    logic                  inv_in, spec_hit;

    logic                  sign_q;
    logic [EXP_W-1:0]      exp_a_q, exp_b_q;
    logic [11:0]           rem_q, mb_q;
    logic [DIV_ITERS-1:0]  quo_q;
    logic [3:0]            cnt_q;
    logic [1:0]            spec_exc_q;

    logic                  ge;
    logic [11:0]           rem_sel, rem_nxt;
    logic signed [6:0]     e_raw, e_fin;
    logic [MAN_W-1:0]      mant;
    logic [15:0]           norm_q;
    logic [1:0]            norm_exc;

    hp_operand_classify u_cls_a (
        .operand   (hp_inA),
        .is_zero   (a_zero),
        .is_denorm (a_den),
        .is_inf    (a_inf),
        .is_nan    (a_nan)
    );

    hp_operand_classify u_cls_b (
        .operand   (hp_inB),
        .is_zero   (b_zero),
        .is_denorm (b_den),
        .is_inf    (b_inf),
        .is_nan    (b_nan)
    );

    assign inv_in   = a_inf | a_nan | b_inf | b_nan | a_den | b_den | b_zero;
    assign spec_hit = inv_in | a_zero;
    assign busy     = (state_q != ST_IDLE);

    // Remainder stays below 2*mb, so dropping the top bit on the shift is lossless.
    assign ge      = (rem_q >= mb_q);
    assign rem_sel = ge ? (rem_q - mb_q) : rem_q;
    assign rem_nxt = {rem_sel[10:0], 1'b0};

    always_comb begin
        e_raw = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q}) + $signed(7'(EXP_BIAS));
        if (quo_q[DIV_ITERS-1]) begin
            e_fin = e_raw;
            mant  = quo_q[DIV_ITERS-2 -: MAN_W];
        end else begin
            e_fin = e_raw - 7'sd1;
            mant  = quo_q[DIV_ITERS-3 -: MAN_W];
        end
`ifdef HP_DIV_ROUND_NEAREST_EN
        begin
            logic          guard, sticky;
            logic [MAN_W:0] mant_r;
            guard  = quo_q[DIV_ITERS-1] ? quo_q[2] : quo_q[1];
            sticky = (quo_q[DIV_ITERS-1] ? (|quo_q[1:0]) : quo_q[0]) | (rem_q != '0);
            mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, guard & (sticky | mant[0])};
            mant   = mant_r[MAN_W-1:0];
            if (mant_r[MAN_W]) e_fin = e_fin + 7'sd1;
        end
`endif
        if (e_fin < E_MIN) begin
            norm_exc = EXC_UNF;
            norm_q   = '0;
        end else if (e_fin > E_MAX) begin
            norm_exc = EXC_OVF;
            norm_q   = '0;
        end else begin
            norm_exc = EXC_NONE;
            norm_q   = {sign_q, e_fin[EXP_W-1:0], mant};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = spec_hit ? ST_SPECIAL : ST_DIV;
            ST_SPECIAL: state_d = ST_IDLE;
            ST_DIV:     if (cnt_q == 4'(DIV_ITERS-1)) state_d = ST_NORM;
            ST_NORM:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q      <= 1'b0;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            rem_q       <= '0;
            mb_q        <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            spec_exc_q  <= EXC_NONE;
            done        <= 1'b0;
            hp_quotient <= '0;
            Exceptions  <= EXC_NONE;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    sign_q     <= hp_inA[15] ^ hp_inB[15];
                    exp_a_q    <= hp_inA[MAN_W +: EXP_W];
                    exp_b_q    <= hp_inB[MAN_W +: EXP_W];
                    rem_q      <= {1'b0, 1'b1, hp_inA[MAN_W-1:0]};
                    mb_q       <= {1'b0, 1'b1, hp_inB[MAN_W-1:0]};
                    quo_q      <= '0;
                    cnt_q      <= '0;
                    spec_exc_q <= inv_in ? EXC_INV : EXC_NONE;
                end
                ST_SPECIAL: begin
                    hp_quotient <= '0;
                    Exceptions  <= spec_exc_q;
                    done        <= 1'b1;
                end
                ST_DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[DIV_ITERS-2:0], ge};
                    cnt_q <= cnt_q + 4'd1;
                end
                ST_NORM: begin
                    hp_quotient <= norm_q;
                    Exceptions  <= norm_exc;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_divider.sv
// Directed self-checking bench for hp_divider (either setting of HP_DIV_ROUND_NEAREST_EN).
module tb_hp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] hp_inA, hp_inB;
    logic        busy, done;
    logic [15:0] hp_quotient;
    logic [1:0]  Exceptions;

    int checks   = 0;
    int failures = 0;

`ifdef HP_DIV_ROUND_NEAREST_EN
    localparam int NORM_LAT = 15;
`else
    localparam int NORM_LAT = 13;
`endif
    localparam int SPEC_LAT = 1;

    hp_divider #(.EXP_BIAS(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hp_inA      (hp_inA),
        .hp_inB      (hp_inB),
        .busy        (busy),
        .done        (done),
        .hp_quotient (hp_quotient),
        .Exceptions  (Exceptions)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        hp_inA = a;
        hp_inB = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_q, input logic [1:0] exp_e, input int exp_lat);
        int lat;
        launch(a, b);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_q"}, 32'(hp_quotient), 32'(exp_q));
        check({tag, "_exc"}, 32'(Exceptions), 32'(exp_e));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        int first_k;
        logic [15:0] got_q;
        logic [1:0]  got_e;

        rst    = 1'b1;
        start  = 1'b0;
        hp_inA = '0;
        hp_inB = '0;
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_q", 32'(hp_quotient), 32'd0);
        check("rst_exc", 32'(Exceptions), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("div_3_2",    16'h4200, 16'h4000, 16'h3E00, 2'b00, NORM_LAT);
        run("div_m3_2",   16'hC200, 16'h4000, 16'hBE00, 2'b00, NORM_LAT);
        run("div_1_3",    16'h3C00, 16'h4200, 16'h3555, 2'b00, NORM_LAT);
        run("div_by_0",   16'h3C00, 16'h0000, 16'h0000, 2'b11, SPEC_LAT);
        run("zero_div",   16'h0000, 16'h4000, 16'h0000, 2'b00, SPEC_LAT);
        run("inf_a",      16'h7C00, 16'h4000, 16'h0000, 2'b11, SPEC_LAT);
        run("denorm_b",   16'h3C00, 16'h0001, 16'h0000, 2'b11, SPEC_LAT);
        run("div_1_3_b",  16'h3C00, 16'h4200, 16'h3555, 2'b00, NORM_LAT);
        run("ovf",        16'h7800, 16'h0400, 16'h0000, 2'b01, NORM_LAT);
        run("div_1_3_c",  16'h3C00, 16'h4200, 16'h3555, 2'b00, NORM_LAT);
        run("unf",        16'h0400, 16'h7800, 16'h0000, 2'b10, NORM_LAT);

        // Second start and changed operands mid-operation must be ignored.
        launch(16'h4200, 16'h4000);
        repeat (5) @(posedge clk);
        #1;
        start  = 1'b1;
        hp_inA = 16'h3C00;
        hp_inB = 16'h4200;
        @(posedge clk);
        #1;
        start   = 1'b0;
        ndone   = 0;
        first_k = 0;
        got_q   = '0;
        got_e   = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (first_k == 0) begin
                    first_k = k;
                    got_q   = hp_quotient;
                    got_e   = Exceptions;
                end
            end
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_lat", 32'(first_k), 32'(NORM_LAT - 6));
        check("ign_q", 32'(got_q), 32'h3E00);
        check("ign_exc", 32'(got_e), 32'd0);

        // Asynchronous reset mid-operation aborts without a done pulse.
        run("pre_abort", 16'h3C00, 16'h4200, 16'h3555, 2'b00, NORM_LAT);
        launch(16'h4200, 16'h4000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_q", 32'(hp_quotient), 32'd0);
        check("abort_exc", 32'(Exceptions), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("abort_nodone", 32'(ndone), 32'd0);
        run("post_abort", 16'h4200, 16'h4000, 16'h3E00, 2'b00, NORM_LAT);

        // Start held high relaunches on the edge after done.
        launch(16'h3C00, 16'h0000);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("hold_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_relaunch_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("hold_relaunch_done", 32'(done), 32'd1);
        check("hold_relaunch_exc", 32'(Exceptions), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hp_divider.md
Name: hp_divider

Overview:
- Sequential IEEE-754 half-precision divider: quotient = hp_inA / hp_inB.
- Inverse-operation companion to the half-precision multiplier.
- Uses the same operand classification, exception encoding and truncation policy.
- Iterative restoring division on 11-bit significands under a start/busy/done handshake; one quotient bit per cycle.

Parameters:
- EXP_BIAS, 15, exponent bias added after exponent subtraction.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- hp_inA  input  16  dividend {sign, exp[4:0], man[9:0]}
- hp_inB  input  16  divisor, same format
- busy  output  1  high from the start-accept edge until the done edge
- done  output  1  one-cycle pulse; hp_quotient and Exceptions valid
- hp_quotient  output  16  result; held until the next completion
- Exceptions  output  2  00 valid, 01 overflow, 10 underflow, 11 invalid input

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; hp_quotient=16'h0000; Exceptions=2'b00. An operation in flight is aborted and produces no done.
- States: IDLE, SPECIAL, DIV, NORM.
- IDLE, start=1 at edge E0: operands are latched and classified in priority order:
  - Either input inf or NaN (exp=31) -> 11.
  - Either input denormal (exp=0, man!=0) -> 11.
  - Divisor zero -> 11.
  - Dividend zero -> result 16'h0000, Exceptions 00.
  - Any of the above -> SPECIAL. Otherwise -> DIV with count=0.
- SPECIAL: at E1 write hp_quotient (16'h0000 for all exception cases), write Exceptions, done=1, busy=0, return to IDLE.
- DIV: ma={1,manA}, mb={1,manB}, remainder r=ma (12-bit). Each edge: if r>=mb then qbit=1 and r=r-mb, else qbit=0; then r=r<<1 and q={q[10:0],qbit}. Runs 12 iterations (E1..E12), then -> NORM.
- NORM at E13:
  - Exponent: e = expA - expB + EXP_BIAS, as 7-bit signed.
  - If q[11]=1: mantissa=q[10:1]. Else: mantissa=q[9:0] and e=e-1.
  - Sign = signA ^ signB.
  - e<1 -> Exceptions 10, hp_quotient=0. e>30 -> 01, hp_quotient=0. Otherwise 00, hp_quotient={sign, e[4:0], mantissa}.
  - done=1, busy=0, -> IDLE.
- Latency: done is high in the cycle after E13 (normal path) or after E1 (special path).
- start while busy is ignored. start held high continuously re-launches from IDLE the cycle after done.
- Inputs are only sampled at E0; changes during busy have no effect.
- Default rounding: truncation toward zero.

Optional Feature:
- Macro HP_DIV_ROUND_NEAREST_EN.
- Defined:
  - DIV runs 14 iterations (guard and round bits); sticky = (final r != 0).
  - NORM applies round-to-nearest-even to the 10-bit mantissa. A mantissa carry-out increments e before the range check.
  - Normal-path latency becomes E15.
- Undefined: 12 iterations, truncation, latency as above.

Decomposition:
- Package hp_fp_pkg holds:
  - Field widths (EXP_W=5, MAN_W=10).
  - HP_BIAS=15 and HP_EXP_MAX=30.
  - Exception constants EXC_NONE=2'b00, EXC_OVF=2'b01, EXC_UNF=2'b10, EXC_INV=2'b11.
  - State enum.
- One sub-module, hp_operand_classify: combinational. Takes a 16-bit operand and outputs is_zero, is_denorm, is_inf, is_nan. Instantiated twice.
- Divide datapath and FSM stay in hp_divider.

Test Plan:
- A=16'h4200, B=16'h4000 (3/2), start pulse -> done one cycle after E13 (E15 with macro); hp_quotient=16'h3E00, Exceptions=00. Repeat with A=16'hC200 -> 16'hBE00.
- A=16'h3C00, B=16'h4200 (1/3) -> q[11]=0 normalization path; hp_quotient=16'h3555, Exceptions=00, both macro settings.
- B=16'h0000, A=16'h3C00 -> 11, done one cycle after E1. A=16'h0000, B=16'h4000 -> 16'h0000/00. A=16'h7C00 -> 11. B=16'h0001 (denormal) -> 11.
- A=16'h7800, B=16'h0400 -> Exceptions=01. A=16'h0400, B=16'h7800 -> Exceptions=10. hp_quotient=0 in both.
- Second start pulse and changed inputs at E5 -> ignored; result is for the original operands and exactly one done pulse.
- rst asserted at E6 asynchronously -> outputs zero immediately, no done. A new start after release -> correct result.
